// File: rtl/i2c_csr_bridge.sv
// i2c_csr_bridge: I2C target that exposes a 5-bit CSR address space.
//
// Protocol: S <addr,W> <ptr> <data>* P writes data at the pointer;
//           S <addr,R> <data>* P reads data from the pointer.
// The pointer holds its value across STOP and repeated START.
//
// Ports:
//   clk     sole clock
//   rst     asynchronous active-high reset
//   scl_i   raw I2C SCL (asynchronous)
//   sda_i   raw I2C SDA (asynchronous)
//   sda_oe  1 = pull SDA low, 0 = release (open drain)
//   csr_a   CSR address (always the pointer)
//   csr_do  CSR write data
//   csr_we  CSR write strobe, one clk wide
//   csr_di  CSR read data, combinational from csr_a
//
// Build option: define CSR_AUTOINC_EN to advance the pointer after every
// written byte and after every captured read byte.
module i2c_csr_bridge #(
    parameter logic [6:0] I2C_ADDR = 7'h4a
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [4:0] csr_a,
    output logic [7:0] csr_do,
    output logic       csr_we,
    input  logic [7:0] csr_di
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // Synchronizers (s1, s2) plus one edge-detect stage (s3)
    logic scl_s1_q, scl_s2_q, scl_s3_q, scl_s1_d, scl_s2_d, scl_s3_d;
    logic sda_s1_q, sda_s2_q, sda_s3_q, sda_s1_d, sda_s2_d, sda_s3_d;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] sr_q, sr_d;
    logic [4:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] csr_do_q, csr_do_d;
    logic       csr_we_q, csr_we_d;
`ifdef CSR_AUTOINC_EN
    logic       rd_cap_q, rd_cap_d;
`endif

    logic       scl_rise, scl_fall, start_det, stop_det, load_rd;
    logic [7:0] rx_byte;

    assign scl_rise  =  scl_s2_q & ~scl_s3_q;
    assign scl_fall  = ~scl_s2_q &  scl_s3_q;
    assign start_det =  scl_s2_q &  scl_s3_q &  sda_s3_q & ~sda_s2_q;
    assign stop_det  =  scl_s2_q &  scl_s3_q & ~sda_s3_q &  sda_s2_q;
    assign rx_byte   = {sr_q, sda_s2_q};

    always_comb begin
        scl_s1_d  = scl_i;
        scl_s2_d  = scl_s1_q;
        scl_s3_d  = scl_s2_q;
        sda_s1_d  = sda_i;
        sda_s2_d  = sda_s1_q;
        sda_s3_d  = sda_s2_q;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        csr_do_d  = csr_do_q;
        csr_we_d  = 1'b0;
        load_rd   = 1'b0;
`ifdef CSR_AUTOINC_EN
        rd_cap_d  = 1'b0;
        if (csr_we_q || rd_cap_q)
            ptr_d = ptr_q + 5'd1;
`endif

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        sr_d      = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            // bit_cnt = 8 marks "ACK slot not yet started"
                            bit_cnt_d = 4'd8;
                            if (state_q == ADDR) begin
                                if (rx_byte[7:1] == I2C_ADDR) begin
                                    state_d = ADDR_ACK;
                                    rw_d    = rx_byte[0];
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (state_q == PTR) begin
                                ptr_d   = rx_byte[4:0];
                                state_d = PTR_ACK;
                            end else begin
                                csr_do_d = rx_byte;
                                csr_we_d = 1'b1;
                                state_d  = WDATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            if (state_q == ADDR_ACK && rw_q)
                                load_rd = 1'b1;
                            else if (state_q == ADDR_ACK)
                                state_d = PTR;
                            else
                                state_d = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd8;
                            state_d   = RDATA_ACK;
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~sr_q[6];
                        sr_d     = {sr_q[5:0], 1'b0};
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                        end else begin
                            load_rd = 1'b1;
                        end
                    end else if (scl_rise && bit_cnt_q == 4'd0 && sda_s2_q) begin
                        state_d = IGNORE;
                    end
                end
                IGNORE:  sda_oe_d = 1'b0;
                default: ;
            endcase
        end

        // Read byte capture: MSB goes straight to SDA, rest held for shifting
        if (load_rd) begin
            state_d   = RDATA;
            bit_cnt_d = '0;
            sr_d      = csr_di[6:0];
            sda_oe_d  = ~csr_di[7];
`ifdef CSR_AUTOINC_EN
            rd_cap_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            scl_s3_q  <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            sda_s3_q  <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            csr_do_q  <= '0;
            csr_we_q  <= 1'b0;
`ifdef CSR_AUTOINC_EN
            rd_cap_q  <= 1'b0;
`endif
        end else begin
            scl_s1_q  <= scl_s1_d;
            scl_s2_q  <= scl_s2_d;
            scl_s3_q  <= scl_s3_d;
            sda_s1_q  <= sda_s1_d;
            sda_s2_q  <= sda_s2_d;
            sda_s3_q  <= sda_s3_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            csr_do_q  <= csr_do_d;
            csr_we_q  <= csr_we_d;
`ifdef CSR_AUTOINC_EN
            rd_cap_q  <= rd_cap_d;
`endif
        end
    end

    assign sda_oe = sda_oe_q;
    assign csr_a  = ptr_q;
    assign csr_do = csr_do_q;
    assign csr_we = csr_we_q;

endmodule

// File: tb/tb_i2c_csr_bridge.sv
// Directed testbench for i2c_csr_bridge: acts as I2C master on an
// open-drain bus model and as a simple CSR read-data table.
`timescale 1ns/1ps
module tb_i2c_csr_bridge;

    localparam int Q = 100;  // quarter of an SCL bit period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, csr_we;
    logic [4:0] csr_a;
    logic [7:0] csr_do, csr_di;
    logic [7:0] rd_tbl [32];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [4:0] we_a_log [16];
    logic [7:0] we_d_log [16];

    assign sda_line = sda_m & ~sda_oe;
    assign csr_di   = rd_tbl[csr_a];

    i2c_csr_bridge #(.I2C_ADDR(7'h4a)) dut (
        .clk    (clk),
        .rst    (rst),
        .scl_i  (scl_m),
        .sda_i  (sda_line),
        .sda_oe (sda_oe),
        .csr_a  (csr_a),
        .csr_do (csr_do),
        .csr_we (csr_we),
        .csr_di (csr_di)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (csr_we) begin
            if (we_cnt < 16) begin
                we_a_log[we_cnt] = csr_a;
                we_d_log[we_cnt] = csr_do;
            end
            we_cnt = we_cnt + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        ack = ~sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; #Q;
            scl_m = 1'b1; #Q;
            d[i] = sda_line; #Q;
            scl_m = 1'b0; #Q;
        end
        send_bit(~mack);
    endtask

    logic       ack;
    logic [7:0] rd;

    initial begin
        for (int i = 0; i < 32; i++) rd_tbl[i] = 8'h00;
        rd_tbl[2] = 8'h3c;
        rd_tbl[3] = 8'h5e;
        rd_tbl[4] = 8'h81;
        rd_tbl[5] = 8'h42;

        // Reset values
        #23;
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_csr_we", {31'd0, csr_we}, 32'd0);
        check("rst_csr_a",  {27'd0, csr_a},  32'd0);
        check("rst_csr_do", {24'd0, csr_do}, 32'd0);
        #30 rst = 1'b0;
        #(2*Q);

        // Wrong address (0x4b): no ACKs, no writes, pointer unchanged
        i2c_start();
        send_byte(8'h96, ack); check("nomatch_addr_ack", {31'd0, ack}, 32'd0);
        send_byte(8'h01, ack); check("nomatch_ptr_ack",  {31'd0, ack}, 32'd0);
        send_byte(8'ha5, ack); check("nomatch_data_ack", {31'd0, ack}, 32'd0);
        i2c_stop(); #Q;
        check("nomatch_we_cnt", we_cnt, 32'd0);
        check("nomatch_csr_a", {27'd0, csr_a}, 32'd0);

        // Single write 0xa5 to register 1
        i2c_start();
        send_byte(8'h94, ack); check("wr1_addr_ack", {31'd0, ack}, 32'd1);
        send_byte(8'h01, ack); check("wr1_ptr_ack",  {31'd0, ack}, 32'd1);
        send_byte(8'ha5, ack); check("wr1_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop(); #Q;
        check("wr1_we_cnt", we_cnt, 32'd1);
        check("wr1_we_a", {27'd0, we_a_log[0]}, 32'h01);
        check("wr1_we_d", {24'd0, we_d_log[0]}, 32'ha5);
`ifdef CSR_AUTOINC_EN
        check("wr1_ptr_after", {27'd0, csr_a}, 32'h02);
`else
        check("wr1_ptr_after", {27'd0, csr_a}, 32'h01);
`endif

        // Write 0x6b to register 2, then read back, master NACK
        i2c_start();
        send_byte(8'h94, ack); check("wd_addr_ack", {31'd0, ack}, 32'd1);
        send_byte(8'h02, ack); check("wd_ptr_ack",  {31'd0, ack}, 32'd1);
        send_byte(8'h6b, ack); check("wd_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop(); #Q;
        check("wd_we_cnt", we_cnt, 32'd2);
        check("wd_we_a", {27'd0, we_a_log[1]}, 32'h02);
        check("wd_we_d", {24'd0, we_d_log[1]}, 32'h6b);
        i2c_start();
        send_byte(8'h95, ack); check("rd_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(1'b0, rd);
`ifdef CSR_AUTOINC_EN
        check("rd_byte", {24'd0, rd}, 32'h5e);
`else
        check("rd_byte", {24'd0, rd}, 32'h3c);
`endif
        check("rd_sda_released_nack", {31'd0, sda_oe}, 32'd0);
        i2c_stop(); #Q;
        check("rd_sda_released_stop", {31'd0, sda_oe}, 32'd0);

        // Burst read: ACK then NACK
        i2c_start();
        send_byte(8'h95, ack); check("brd_addr_ack", {31'd0, ack}, 32'd1);
        read_byte(1'b1, rd);
`ifdef CSR_AUTOINC_EN
        check("brd_byte0", {24'd0, rd}, 32'h81);
`else
        check("brd_byte0", {24'd0, rd}, 32'h3c);
`endif
        read_byte(1'b0, rd);
`ifdef CSR_AUTOINC_EN
        check("brd_byte1", {24'd0, rd}, 32'h42);
`else
        check("brd_byte1", {24'd0, rd}, 32'h3c);
`endif
        i2c_stop(); #Q;
        check("brd_no_we", we_cnt, 32'd2);
`ifdef CSR_AUTOINC_EN
        check("brd_ptr_after", {27'd0, csr_a}, 32'h06);
`else
        check("brd_ptr_after", {27'd0, csr_a}, 32'h02);
`endif

        // Burst write at 0x1f (wraps when auto-increment is built in)
        i2c_start();
        send_byte(8'h94, ack);
        send_byte(8'h1f, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack); check("bwr_last_ack", {31'd0, ack}, 32'd1);
        i2c_stop(); #Q;
        check("bwr_we_cnt", we_cnt, 32'd4);
        check("bwr_we_a0", {27'd0, we_a_log[2]}, 32'h1f);
        check("bwr_we_d0", {24'd0, we_d_log[2]}, 32'h11);
`ifdef CSR_AUTOINC_EN
        check("bwr_we_a1", {27'd0, we_a_log[3]}, 32'h00);
`else
        check("bwr_we_a1", {27'd0, we_a_log[3]}, 32'h1f);
`endif
        check("bwr_we_d1", {24'd0, we_d_log[3]}, 32'h22);

        // Reset during the 4th data bit of 0xa5
        i2c_start();
        send_byte(8'h94, ack);
        send_byte(8'h01, ack);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        rst = 1'b1; #1;
        check("mrst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("mrst_csr_a",  {27'd0, csr_a},  32'd0);
        check("mrst_csr_we", {31'd0, csr_we}, 32'd0);
        #49 rst = 1'b0;
        #20 sda_m = 1'b1;   // STOP right after reset release
        #(2*Q);
        check("mrst_no_we", we_cnt, 32'd4);
        check("mrst_ptr", {27'd0, csr_a}, 32'd0);

        // Normal write afterwards
        i2c_start();
        send_byte(8'h94, ack); check("post_addr_ack", {31'd0, ack}, 32'd1);
        send_byte(8'h07, ack); check("post_ptr_ack",  {31'd0, ack}, 32'd1);
        send_byte(8'h3c, ack); check("post_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop(); #Q;
        check("post_we_cnt", we_cnt, 32'd5);
        check("post_we_a", {27'd0, we_a_log[4]}, 32'h07);
        check("post_we_d", {24'd0, we_d_log[4]}, 32'h3c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_csr_bridge.md
I2C_CSR_BRIDGE -- requirements
Module: i2c_csr_bridge

Interface
REQ-001 Parameter I2C_ADDR, default 7'h4a: 7-bit I2C target address the bridge answers to.
REQ-002 clk  input  1  sole clock; all logic in this domain.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 scl_i  input  1  raw I2C SCL, asynchronous to clk.
REQ-005 sda_i  input  1  raw I2C SDA, asynchronous to clk.
REQ-006 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 csr_a  output  5  CSR bus address to all register blocks.
REQ-008 csr_do  output  8  CSR write data, wired to every block's csr_di.
REQ-009 csr_we  output  1  CSR write strobe, one clk wide.
REQ-010 csr_di  input  8  CSR read data, OR of all blocks' csr_do; combinational from csr_a.

Function
REQ-011 scl_i/sda_i SHALL pass through 2-FF synchronizers; edges and START/STOP SHALL be detected on synchronized values, one extra register stage for edge detect.
REQ-012 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both SHALL be honoured in every state.
REQ-013 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-014 START (incl. repeated START) from any state -> ADDR, bit counter cleared; STOP from any state -> IDLE, sda_oe released.
REQ-015 Bits SHALL be sampled on detected SCL rising edge, MSB first; sda_oe SHALL change only on the clk after a detected SCL falling edge.
REQ-016 ADDR: after 8 bits, address match -> ADDR_ACK (sda_oe=1 for the 9th clock); mismatch -> IGNORE (sda_oe=0 until next START/STOP).
REQ-017 ADDR_ACK exit on SCL falling: R/W=0 -> PTR; R/W=1 -> RDATA.
REQ-018 PTR: 8th bit received -> pointer <= byte[4:0] (bits 7:5 discarded), ACK, -> WDATA after ACK.
REQ-019 WDATA: on the clk after the 8th SCL rising edge, csr_we=1 for exactly one clk with csr_a=pointer, csr_do=received byte; ACK driven; -> WDATA_ACK -> WDATA.
REQ-020 csr_a SHALL equal the pointer at all times outside reset.
REQ-021 RDATA entry (SCL falling ending ADDR_ACK or RDATA_ACK): shift register <= csr_di in that same clk; MSB driven on sda_oe = ~bit.
REQ-022 RDATA: after 8th bit, sda_oe=0; master ACK (SDA low at 9th rising) -> RDATA again; NACK -> IGNORE.
REQ-023 Pointer arithmetic 5-bit, 5'h1f + 1 wraps to 5'h00.
REQ-024 Reads SHALL never assert csr_we; writes SHALL never occur in IGNORE or on address mismatch.
REQ-025 Pointer SHALL survive STOP and repeated START; only a PTR byte or reset changes it (apart from REQ-031).

Reset
REQ-026 Asserting rst SHALL immediately force: state IDLE, pointer 5'h00, csr_a 5'h00, csr_do 8'h00, csr_we 0, sda_oe 0, synchronizers to 1 (bus idle).
REQ-027 Reset mid-transfer SHALL abort without a partial csr_we; after release, the bridge waits for a new START.
REQ-028 A STOP seen in the first cycle after release SHALL not be treated as START.

Configuration
REQ-029 Macro CSR_AUTOINC_EN selects pointer auto-increment.
REQ-030 Without CSR_AUTOINC_EN: pointer unchanged by data bytes; burst writes hit one address; burst reads re-read one address.
REQ-031 With CSR_AUTOINC_EN: pointer +1 on the clk after each csr_we, and +1 on the clk after each read-byte capture (REQ-021), wrapping per REQ-023.

Verification
REQ-032 S 0x94 A 0x01 A 0xa5 A P -> exactly one csr_we pulse, csr_a=5'h01, csr_do=8'ha5; three ACKs on SDA.
REQ-033 S 0x94 0x02 0x6b P (watchdog kick) -> csr_we with csr_a=5'h02, csr_do=8'h6b; then Sr 0x95, csr_di=8'h3c at pointer 2 -> 0x3c read, master NACK, P -> bridge releases SDA.
REQ-034 S 0x96 (address 0x4b) 0x01 0xa5 P -> no ACK on any byte, csr_we never asserted, pointer stays 0.
REQ-035 CSR_AUTOINC_EN: S 0x94 0x1f 0x11 0x22 P -> csr_we at 5'h1f (0x11) then 5'h00 (0x22); without macro both at 5'h1f.
REQ-036 rst pulsed during 4th data bit of S 0x94 0x01 0xa5 -> no csr_we, sda_oe=0 immediately, pointer 0; a following full write completes normally.
